// File: rtl/decoder_pipe.sv
// Pipelined address-to-one-hot decoder behind a small FIFO with valid/ready on both sides.
// Outputs are decoded from the registered head entry only, so neither side sees a combinational path.
module decoder_pipe #(
  parameter int ADDR_W    = 5,
  parameter int N_OUT     = 32,
  parameter int DEPTH     = 2,
  parameter bit ZERO_MASK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_onehot,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_hit,
  output logic              out_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      N_OUT_C = 32'(N_OUT);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [DEPTH-1:0]  en_mem_q, en_mem_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic              head_en;
  logic [31:0]       head_addr_ext;
  logic              addr_oor;
  logic              zero_hit;

  // No pass-through when full: a pop in the same cycle does not open a slot.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    addr_mem_d = addr_mem_q;
    en_mem_d   = en_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = in_addr;
      en_mem_d[wr_ptr_q]   = in_en;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
      end
      en_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_mem_q <= addr_mem_d;
      en_mem_q   <= en_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head_addr     = addr_mem_q[rd_ptr_q];
  assign head_en       = en_mem_q[rd_ptr_q];
  assign head_addr_ext = {{(32-ADDR_W){1'b0}}, head_addr};
  assign addr_oor      = (head_addr_ext >= N_OUT_C);
  assign zero_hit      = ZERO_MASK && (head_addr == '0);

  // Every term is gated by out_valid so stale memory never leaks onto the outputs.
  always_comb begin
    out_onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_onehot[i] = out_valid && head_en && !addr_oor && !zero_hit
                      && (head_addr_ext == 32'(i));
    end
  end

  assign out_err  = out_valid && addr_oor;
  assign out_hit  = |out_onehot;
  assign out_addr = out_valid ? head_addr : '0;

endmodule
